// File: rtl/iteration_var_scatter.sv
// iteration_var_scatter: route one iteration-variable word into a selected program-block slot, all other slots held at zero
module iteration_var_scatter #(
  parameter int MAX_NO_OF_PROGRAM_BLOCKS = 12,
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter int SEL_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [SEL_WIDTH-1:0] in_sel,
  input  logic [ITERATION_VARIABLE_WIDTH-1:0] in_value,
  input  logic release_req,
  output logic [0:MAX_NO_OF_PROGRAM_BLOCKS*ITERATION_VARIABLE_WIDTH-1] out,
  output logic [MAX_NO_OF_PROGRAM_BLOCKS-1:0] active_onehot,
  output logic busy,
  output logic sel_error
);
  localparam int N = MAX_NO_OF_PROGRAM_BLOCKS;
  localparam int W = ITERATION_VARIABLE_WIDTH;
  typedef enum logic [1:0] {IDLE, DRIVE, CLEAR} state_t;
  state_t state;
  logic accept, sel_ok;
  logic [0:N*W-1] next_out;
  logic [N-1:0] next_hot;
  assign in_ready = !rst && state != CLEAR;
  assign busy = state == DRIVE || state == CLEAR;
  assign accept = in_valid && in_ready;
  assign sel_ok = 32'(in_sel) < N;
  // Build the bus image with only the selected slot carrying the new word
  always_comb begin
    next_out = '0;
    next_hot = '0;
    for (int i = 0; i < N; i++) begin
      next_out[i*W +: W] = in_sel == SEL_WIDTH'(i) ? in_value : '0;
      next_hot[i] = in_sel == SEL_WIDTH'(i);
    end
  end
  // Load/retarget wins over release; release drops into a one-cycle clear guard
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out <= '0;
      active_onehot <= '0;
      sel_error <= 1'b0;
    end else begin
      sel_error <= accept && !sel_ok;
      if (accept && sel_ok) begin
        out <= next_out;
        active_onehot <= next_hot;
        state <= DRIVE;
      end else if (state == DRIVE && release_req) begin
        out <= '0;
        active_onehot <= '0;
        state <= CLEAR;
      end else if (state == CLEAR) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_iteration_var_scatter.sv
// tb_iteration_var_scatter: directed and model-checked random tests for the iteration-variable scatter
module tb_iteration_var_scatter;
  logic clk = 1'b0, rst, in_valid, release_req, in_ready, busy, sel_error;
  logic [3:0] in_sel;
  logic [15:0] in_value;
  logic [0:191] out, exp_out;
  logic [11:0] active_onehot;
  int checks = 0, failures = 0;

  iteration_var_scatter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_value(in_value), .release_req(release_req), .out(out), .active_onehot(active_onehot),
    .busy(busy), .sel_error(sel_error)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] slot(int i);
    return out[i*16 +: 16];
  endfunction

  function automatic logic [15:0] ored();
    logic [15:0] r = '0;
    for (int i = 0; i < 12; i++) r |= out[i*16 +: 16];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] s, input logic [15:0] v, input logic r);
    in_valid = 1'b1; in_sel = s; in_value = v; release_req = r;
    tick();
    in_valid = 1'b0; release_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; release_req = 1'b0; in_sel = '0; in_value = '0;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
    checks++; if (out !== '0) begin failures++; $display("FAIL reset_out got=%h exp=0", out); end
    checks++; if ({active_onehot, busy, sel_error} !== '0) begin failures++; $display("FAIL reset_flags hot=%h busy=%b err=%b exp=0", active_onehot, busy, sel_error); end
    rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_load();
    load(4'd3, 16'h0042, 1'b0);
    exp_out = '0; exp_out[48 +: 16] = 16'h0042;
    checks++; if (out !== exp_out) begin failures++; $display("FAIL load_out got=%h exp=%h", out, exp_out); end
    checks++; if (active_onehot !== 12'h008 || busy !== 1'b1) begin failures++; $display("FAIL load_flags hot=%h busy=%b exp=008/1", active_onehot, busy); end
  endtask

  task automatic test_retarget();
    load(4'd11, 16'hFFFF, 1'b0);
    checks++; if (slot(3) !== 16'h0 || slot(11) !== 16'hFFFF) begin failures++; $display("FAIL retarget_slots s3=%h s11=%h exp=0/ffff", slot(3), slot(11)); end
    checks++; if (active_onehot !== 12'h800) begin failures++; $display("FAIL retarget_hot got=%h exp=800", active_onehot); end
    checks++; if (ored() !== 16'hFFFF) begin failures++; $display("FAIL retarget_or got=%h exp=ffff", ored()); end
  endtask

  task automatic test_release();
    release_req = 1'b1; tick(); release_req = 1'b0;
    checks++; if (out !== '0 || active_onehot !== '0) begin failures++; $display("FAIL release_out out=%h hot=%h exp=0", out, active_onehot); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL release_clear ready=%b busy=%b exp=0/1", in_ready, busy); end
    tick();
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL release_idle ready=%b busy=%b exp=1/0", in_ready, busy); end
  endtask

  task automatic test_release_and_load();
    load(4'd2, 16'h1234, 1'b0);
    load(4'd5, 16'h0007, 1'b1);
    exp_out = '0; exp_out[80 +: 16] = 16'h0007;
    checks++; if (out !== exp_out) begin failures++; $display("FAIL rel_load_out got=%h exp=%h", out, exp_out); end
    checks++; if (active_onehot !== 12'h020 || busy !== 1'b1 || in_ready !== 1'b1) begin failures++; $display("FAIL rel_load_flags hot=%h busy=%b ready=%b exp=020/1/1", active_onehot, busy, in_ready); end
    release_req = 1'b1; tick(); release_req = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rel_load_still_drive ready=%b exp=0", in_ready); end
    tick();
  endtask

  task automatic test_sel_error();
    load(4'd12, 16'hABCD, 1'b0);
    checks++; if (sel_error !== 1'b1 || out !== '0 || active_onehot !== '0 || busy !== 1'b0) begin failures++; $display("FAIL selerr_idle err=%b hot=%h busy=%b exp=1/000/0", sel_error, active_onehot, busy); end
    tick();
    checks++; if (sel_error !== 1'b0) begin failures++; $display("FAIL selerr_pulse got=%b exp=0", sel_error); end
    load(4'd4, 16'h0055, 1'b0);
    load(4'd15, 16'h0099, 1'b0);
    exp_out = '0; exp_out[64 +: 16] = 16'h0055;
    checks++; if (sel_error !== 1'b1 || out !== exp_out || active_onehot !== 12'h010) begin failures++; $display("FAIL selerr_drive err=%b hot=%h s4=%h exp=1/010/0055", sel_error, active_onehot, slot(4)); end
    tick();
    checks++; if (sel_error !== 1'b0 || out !== exp_out || busy !== 1'b1) begin failures++; $display("FAIL selerr_drive_after err=%b s4=%h busy=%b exp=0/0055/1", sel_error, slot(4), busy); end
  endtask

  task automatic test_zero_value();
    load(4'd6, 16'h0000, 1'b0);
    checks++; if (out !== '0 || active_onehot !== 12'h040 || busy !== 1'b1) begin failures++; $display("FAIL zero_value out=%h hot=%h busy=%b exp=0/040/1", out, active_onehot, busy); end
  endtask

  task automatic test_reset_mid();
    load(4'd7, 16'h8000, 1'b0);
    checks++; if (slot(7) !== 16'h8000) begin failures++; $display("FAIL mid_load got=%h exp=8000", slot(7)); end
    rst = 1'b1; tick();
    checks++; if (out !== '0 || active_onehot !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_reset hot=%h busy=%b ready=%b exp=0/0/0", active_onehot, busy, in_ready); end
    rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_random();
    int m_state = 0, m_sel = 0;
    logic [15:0] m_val = '0;
    logic m_err;
    logic [11:0] m_hot;
    for (int c = 0; c < 10000; c++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_sel = 4'($urandom_range(0, 15));
      in_value = 16'($urandom_range(0, 65535));
      release_req = ($urandom_range(0, 4) == 0);
      m_err = in_valid && m_state != 2 && in_sel >= 4'd12;
      if (in_valid && m_state != 2 && in_sel < 4'd12) begin m_state = 1; m_sel = int'(in_sel); m_val = in_value; end
      else if (m_state == 1 && release_req) m_state = 2;
      else if (m_state == 2) m_state = 0;
      tick();
      exp_out = '0; m_hot = '0;
      if (m_state == 1) begin exp_out[m_sel*16 +: 16] = m_val; m_hot[m_sel] = 1'b1; end
      checks++;
      if (out !== exp_out || active_onehot !== m_hot || sel_error !== m_err || busy !== (m_state != 0) || in_ready !== (m_state != 2) || $countones(active_onehot) > 1) begin
        failures++;
        $display("FAIL random c=%0d hot=%h exp_hot=%h err=%b exp_err=%b busy=%b ready=%b or=%h exp_val=%h", c, active_onehot, m_hot, sel_error, m_err, busy, in_ready, ored(), m_val);
      end
    end
    in_valid = 1'b0; release_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_retarget();
    test_release();
    test_release_and_load();
    test_sel_error();
    test_zero_value();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
